quarter_sine_reader: RTL



---
 rtl/quarter_sine_reader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/quarter_sine_reader.sv
// Quarter-wave sine reader: folds acc+phase_ofs onto a 2**ADDR_WIDTH quarter table and sign-corrects the ROM word.
// Define QSINE_COS_EN to add cos_out (a quarter turn ahead); the ROM port is then time-shared for a 3-cycle busy window.
module quarter_sine_reader #(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PHASE_WIDTH-1:0] phase_inc,
    input  logic [PHASE_WIDTH-1:0] phase_ofs,
    input  logic                   sample_req,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_q,
    output logic [DATA_WIDTH:0]    sample_out,
    output logic                   sample_valid,
    output logic                   busy,
    output logic                   overrun
`ifdef QSINE_COS_EN
    ,
    output logic [DATA_WIDTH:0]    cos_out
`endif
);
    localparam int LO_W  = PHASE_WIDTH - ADDR_WIDTH - 2;
    localparam int TOP_W = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE,
`ifdef QSINE_COS_EN
        S_ISSUE2,
`endif
        S_WAIT,
        S_CAPT
    } state_t;

    state_t                  state_q, state_d;
    logic [PHASE_WIDTH-1:0]  acc_q, acc_d;
    logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
    logic                    neg_q, neg_d;
    logic [DATA_WIDTH:0]     sample_q, sample_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;

    logic                    lo_carry;
    logic [TOP_W-1:0]        p_top;
    logic [ADDR_WIDTH-1:0]   sin_addr;
    logic                    sin_neg;

`ifdef QSINE_COS_EN
    localparam logic [TOP_W-1:0] QUARTER = {2'b01, {ADDR_WIDTH{1'b0}}};
    logic [ADDR_WIDTH-1:0]   cos_addr_q, cos_addr_d;
    logic                    cos_neg_q, cos_neg_d;
    logic [DATA_WIDTH-1:0]   sin_word_q, sin_word_d;
    logic [DATA_WIDTH:0]     cos_q, cos_d;
    logic [TOP_W-1:0]        cos_top;
    logic [ADDR_WIDTH-1:0]   cos_addr;
`endif

    // Only the quadrant/index field of acc+ofs matters; the truncated low bits contribute just their carry.
    generate
        if (LO_W > 0) begin : g_lo
            assign lo_carry = acc_q[LO_W-1:0] > ~phase_ofs[LO_W-1:0];
        end else begin : g_nolo
            assign lo_carry = 1'b0;
        end
    endgenerate

    assign p_top    = acc_q[PHASE_WIDTH-1 -: TOP_W] + phase_ofs[PHASE_WIDTH-1 -: TOP_W]
                    + {{(TOP_W-1){1'b0}}, lo_carry};
    assign sin_addr = p_top[ADDR_WIDTH] ? ~p_top[ADDR_WIDTH-1:0] : p_top[ADDR_WIDTH-1:0];
    assign sin_neg  = p_top[TOP_W-1];

`ifdef QSINE_COS_EN
    assign cos_top  = p_top + QUARTER;
    assign cos_addr = cos_top[ADDR_WIDTH] ? ~cos_top[ADDR_WIDTH-1:0] : cos_top[ADDR_WIDTH-1:0];
`endif

    function automatic logic [DATA_WIDTH:0] apply_sign(input logic neg, input logic [DATA_WIDTH-1:0] mag);
        return neg ? -{1'b0, mag} : {1'b0, mag};
    endfunction

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        rom_addr_d = rom_addr_q;
        neg_d      = neg_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        overrun_d  = 1'b0;
`ifdef QSINE_COS_EN
        cos_addr_d = cos_addr_q;
        cos_neg_d  = cos_neg_q;
        sin_word_d = sin_word_q;
        cos_d      = cos_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sample_req) begin
                    acc_d      = acc_q + phase_inc;
                    rom_addr_d = sin_addr;
                    neg_d      = sin_neg;
`ifdef QSINE_COS_EN
                    cos_addr_d = cos_addr;
                    cos_neg_d  = cos_top[TOP_W-1];
                    state_d    = S_ISSUE2;
`else
                    state_d    = S_WAIT;
`endif
                end
            end
`ifdef QSINE_COS_EN
            S_ISSUE2: begin
                rom_addr_d = cos_addr_q;
                state_d    = S_WAIT;
            end
`endif
            S_WAIT: begin
`ifdef QSINE_COS_EN
                sin_word_d = rom_q;
`endif
                state_d = S_CAPT;
            end
            S_CAPT: begin
`ifdef QSINE_COS_EN
                sample_d = apply_sign(neg_q, sin_word_q);
                cos_d    = apply_sign(cos_neg_q, rom_q);
`else
                sample_d = apply_sign(neg_q, rom_q);
`endif
                valid_d  = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Requests while busy are dropped, not queued.
        if (state_q != S_IDLE && sample_req) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            rom_addr_q <= '0;
            neg_q      <= 1'b0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef QSINE_COS_EN
            cos_addr_q <= '0;
            cos_neg_q  <= 1'b0;
            sin_word_q <= '0;
            cos_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            rom_addr_q <= rom_addr_d;
            neg_q      <= neg_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
`ifdef QSINE_COS_EN
            cos_addr_q <= cos_addr_d;
            cos_neg_q  <= cos_neg_d;
            sin_word_q <= sin_word_d;
            cos_q      <= cos_d;
`endif
        end
    end

    assign rom_addr     = rom_addr_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != S_IDLE);
    assign overrun      = overrun_q;
`ifdef QSINE_COS_EN
    assign cos_out      = cos_q;
`endif

endmodule
